vector_packer: RTL and testbench

- Upstream feeder for the 6-bit ascending-range input stage (`vector2`-style bus, bits [0:5]).
- Accepts a stream of 2-bit ascending-range symbols (`vector1`-style, bits [0:1]) over a valid/ready handshake.
- Packs three consecutive symbols into one 6-bit word and presents it on a registered valid/ready output.
- Supports a flush that emits a partially filled word, zero-padded, with a fill count.

---
 rtl/vector_pkg.sv | 12 +
 rtl/vector_out_reg.sv | 52 +++++
 rtl/vector_packer.sv | 106 ++++++++++
 tb/tb_vector_packer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared types and default sizes for the symbol packer / unpacker pair.
// Ascending bit ranges match the downstream 6-bit input stage.
package vector_pkg;
  localparam int SYM_W  = 2;
  localparam int SYMS   = 3;
  localparam int WORD_W = SYM_W * SYMS;
  localparam int FILL_W = 2;

  typedef logic [0:SYM_W-1]  sym_t;
  typedef logic [0:WORD_W-1] word_t;
  typedef logic [0:FILL_W-1] fill_t;
endpackage

// File: rtl/vector_out_reg.sv
// Single-entry output holding register with valid/ready.
// The producer only asserts load_i when the slot is free (empty or draining),
// so a load and a drain may share a cycle without losing the new entry.
module vector_out_reg #(
  parameter int DATA_W = 6,
  parameter int FILL_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [0:DATA_W-1] data_i,
  input  logic [0:FILL_W-1] fill_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [0:DATA_W-1] data_o,
  output logic [0:FILL_W-1] fill_o
);
  logic              valid_q, valid_d;
  logic [0:DATA_W-1] data_q,  data_d;
  logic [0:FILL_W-1] fill_q,  fill_d;

  // Load wins over drain; otherwise hold contents stable until accepted.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    fill_d  = fill_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      fill_d  = fill_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // State register with synchronous reset clearing data as well as valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      fill_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign fill_o  = fill_q;
endmodule

// File: rtl/vector_packer.sv
// Packs SYMS consecutive SYM_W-bit symbols into one word (first symbol in the
// lowest ascending bits), with a flush that emits a zero-padded partial word.
module vector_packer #(
  parameter int SYM_W = vector_pkg::SYM_W,
  parameter int SYMS  = vector_pkg::SYMS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [0:SYM_W-1]      sym_in,
  input  logic                  sym_valid,
  output logic                  sym_ready,
  input  logic                  flush,
  output logic [0:SYM_W*SYMS-1] word_out,
  output logic [0:1]            word_fill,
  output logic                  word_valid,
  input  logic                  word_ready
);
  import vector_pkg::*;

  localparam int WORD_W = SYM_W * SYMS;
  localparam int CNT_W  = $clog2(SYMS);

  // word_fill is two bits wide, so more than three symbols cannot be counted.
  if (SYMS < 2 || SYMS > 3) begin : g_bad_syms
    $error("vector_packer: SYMS must be in 2..3");
  end

  logic [CNT_W-1:0]  count_q, count_d;
  logic [0:WORD_W-1] partial_q, partial_d, partial_ins;
  logic              flush_pend_q, flush_pend_d;

  logic       at_last, out_free, acc, completing;
  logic       flush_req, emit_flush, load;
  logic [0:1] fill_held;

  assign at_last    = (count_q == CNT_W'(SYMS - 1));
  assign out_free   = !word_valid || word_ready;
  assign sym_ready  = !flush_pend_q && (!at_last || out_free);
  assign acc        = sym_valid && sym_ready;
  assign completing = acc && at_last;

  // A flush only matters if there is something to emit, counting this cycle's symbol.
  assign flush_req  = flush && ((count_q != '0) || acc);
  // A completing symbol already emits a full word, which consumes the flush.
  assign emit_flush = !completing && (flush_pend_q || flush_req) && out_free;
  assign load       = completing || emit_flush;

  // Symbols held after this cycle; equals SYMS for a completing word.
  assign fill_held  = 2'(count_q) + {1'b0, acc};

  // Partial word with this cycle's accepted symbol dropped into slot count.
  always_comb begin
    partial_ins = partial_q;
    if (acc) begin
      for (int k = 0; k < SYMS; k++) begin
        if (count_q == CNT_W'(k)) partial_ins[k*SYM_W +: SYM_W] = sym_in;
      end
    end
  end

  // Accumulate / emit next-state; emitting restarts from an empty partial.
  always_comb begin
    count_d      = count_q;
    partial_d    = partial_q;
    flush_pend_d = flush_pend_q;
    if (load) begin
      count_d      = '0;
      partial_d    = '0;
      flush_pend_d = 1'b0;
    end else begin
      if (acc) begin
        partial_d = partial_ins;
        count_d   = count_q + CNT_W'(1);
      end
      if (flush_req) flush_pend_d = 1'b1;
    end
  end

  // Packing state registers; reset discards any partial word and pending flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      partial_q    <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      partial_q    <= partial_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  vector_out_reg #(
    .DATA_W (WORD_W),
    .FILL_W (2)
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .data_i  (partial_ins),
    .fill_i  (fill_held),
    .ready_i (word_ready),
    .valid_o (word_valid),
    .data_o  (word_out),
    .fill_o  (word_fill)
  );
endmodule

// File: tb/tb_vector_packer.sv
// Directed bench for vector_packer with a queue scoreboard and a separate
// monitor that checks every word handed off downstream.
module tb_vector_packer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [0:1] sym_in = '0;
  logic       sym_valid = 1'b0;
  logic       sym_ready;
  logic       flush = 1'b0;
  logic [0:5] word_out;
  logic [0:1] word_fill;
  logic       word_valid;
  logic       word_ready = 1'b1;

  typedef struct packed {
    logic [0:5] w;
    logic [0:1] f;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   nvec = 0, nfail = 0, stalls = 0, popped = 0;

  always #5 clk = ~clk;

  vector_packer dut (
    .clk        (clk),
    .rst        (rst),
    .sym_in     (sym_in),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .flush      (flush),
    .word_out   (word_out),
    .word_fill  (word_fill),
    .word_valid (word_valid),
    .word_ready (word_ready)
  );

  // Monitor: every accepted word must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && word_valid && word_ready) begin
      nvec++;
      if (sb.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_word: got %b fill %0d, none expected", word_out, word_fill);
      end else begin
        mon_e = sb.pop_front();
        popped++;
        if (word_out !== mon_e.w || word_fill !== mon_e.f) begin
          nfail++;
          $display("FAIL word: got %b fill %0d, expected %b fill %0d",
                   word_out, word_fill, mon_e.w, mon_e.f);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one symbol until accepted; entered and left at posedge+1.
  task automatic send(logic [0:1] s, logic f);
    int n = 0;
    sym_valid = 1'b1;
    sym_in    = s;
    flush     = f;
    @(negedge clk);
    while (!sym_ready && n < 20) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (!sym_ready) begin
      nvec++;
      nfail++;
      $display("FAIL send_timeout: got sym_ready 0 expected 1 within 20 cycles");
    end
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
    flush     = 1'b0;
    sym_in    = '0;
  endtask

  initial begin
    int p0;
    int s0;
    // Reset state
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", word_valid, 0);
    chk("rst_out", word_out, 0);
    chk("rst_fill", word_fill, 0);
    chk("rst_sym_ready", sym_ready, 1);
    idle(1);

    // Basic word, valid for exactly one cycle
    sb.push_back('{6'b01_10_11, 2'd3});
    send(2'b01, 0); send(2'b10, 0); send(2'b11, 0);
    @(negedge clk);
    chk("t1_valid", word_valid, 1);
    idle(1);
    @(negedge clk);
    chk("t1_one_cycle", word_valid, 0);
    idle(1);

    // Back-to-back words at full rate
    stalls = 0;
    p0 = popped;
    sb.push_back('{6'b00_01_10, 2'd3});
    sb.push_back('{6'b11_10_01, 2'd3});
    sb.push_back('{6'b01_11_00, 2'd3});
    send(2'b00, 0); send(2'b01, 0); send(2'b10, 0);
    send(2'b11, 0); send(2'b10, 0); send(2'b01, 0);
    send(2'b01, 0); send(2'b11, 0); send(2'b00, 0);
    chk("t2_no_stall", stalls, 0);
    idle(2);
    chk("t2_words", popped - p0, 3);

    // Backpressure: held word, two more accepted, third stalls
    word_ready = 1'b0;
    sb.push_back('{6'b10_10_01, 2'd3});
    send(2'b10, 0); send(2'b10, 0); send(2'b01, 0);
    s0 = stalls;
    send(2'b11, 0); send(2'b00, 0);
    chk("t3_two_accepted", stalls - s0, 0);
    sb.push_back('{6'b11_00_01, 2'd3});
    sym_valid = 1'b1;
    sym_in    = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_stall_ready", sym_ready, 0);
      chk("t3_hold_out", word_out, 6'b10_10_01);
      chk("t3_hold_valid", word_valid, 1);
      @(posedge clk);
      #1;
    end
    word_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_ready", sym_ready, 1);
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
    sym_in    = '0;
    @(negedge clk);
    chk("t3_next_word", word_out, 6'b11_00_01);
    idle(2);

    // Flush of a partial word, then flush with nothing held
    send(2'b11, 0);
    sb.push_back('{6'b11_00_00, 2'd1});
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    @(negedge clk);
    chk("t4_flush_fill", word_fill, 1);
    idle(1);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_empty_flush", word_valid, 0);
      @(posedge clk);
      #1;
    end

    // Flush together with the completing symbol
    sb.push_back('{6'b01_10_11, 2'd3});
    send(2'b01, 0); send(2'b10, 0); send(2'b11, 1);
    @(negedge clk);
    chk("t5_valid", word_valid, 1);
    chk("t5_fill", word_fill, 3);
    idle(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_trailing", word_valid, 0);
      chk("t5_ready", sym_ready, 1);
      @(posedge clk);
      #1;
    end

    // Reset with a held word and a partial of two symbols
    chk("t6_sb_empty", sb.size(), 0);
    word_ready = 1'b0;
    send(2'b01, 0); send(2'b01, 0); send(2'b01, 0);
    send(2'b10, 0); send(2'b10, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid", word_valid, 0);
    chk("t6_fill", word_fill, 0);
    chk("t6_out", word_out, 0);
    chk("t6_sym_ready", sym_ready, 1);
    idle(1);
    word_ready = 1'b1;
    sb.push_back('{6'b10_01_11, 2'd3});
    send(2'b10, 0); send(2'b01, 0); send(2'b11, 0);
    idle(3);

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
